sram1: RTL and testbench

- Single-port, synchronous 32-bit on-chip data SRAM for the ARM core's memory map.
- Occupies the byte window 0x2000_0000 to 0x2001_7FFF, which is 96 KiB or 24576 words.
- Sits behind the bus as the SRAM1 slave.
- Word accesses only.
- Accesses outside the window are ignored and flagged.

---
 rtl/sram1_pkg.sv | 21 ++
 rtl/sram1_if.sv | 33 +++
 rtl/sram1_addr_decode.sv | 39 +++
 rtl/sram1.sv | 70 +++++++
 tb/tb_sram1.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/sram1_pkg.sv
// sram1_pkg
// Shared constants for the SRAM1 data memory: window base, window size,
// word count and word-index width, plus a helper that derives the index
// width from a byte size.
package sram1_pkg;

    localparam logic [31:0] SRAM1_BASE = 32'h2000_0000;
    localparam logic [31:0] SRAM1_SIZE = 32'h0001_8000;
    localparam int          SRAM1_WORDS = int'(SRAM1_SIZE >> 2);

    // Number of index bits needed for a window of size_bytes bytes.
    // Never less than one so a one-word memory still has a legal index.
    function automatic int sram1_idx_width(input logic [31:0] size_bytes);
        int words;
        words = int'(size_bytes >> 2);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

    localparam int SRAM1_IDX_W = sram1_idx_width(SRAM1_SIZE);

endpackage

// File: rtl/sram1_if.sv
// sram1_if
// Bus-side signals of the SRAM1 slave.
//   read_write   : 1 = write, 0 = read (master -> slave)
//   address      : byte address       (master -> slave)
//   data_in      : write data         (master -> slave)
//   data_out     : registered read data (slave -> master)
//   access_error : registered out-of-window flag (slave -> master)
interface sram1_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  read_write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  access_error;

    modport master (
        output read_write,
        output address,
        output data_in,
        input  data_out,
        input  access_error
    );

    modport slave (
        input  read_write,
        input  address,
        input  data_in,
        output data_out,
        output access_error
    );
endinterface

// File: rtl/sram1_addr_decode.sv
// sram1_addr_decode
// Combinational window check and word-index generation.
//   address    : byte address from the bus
//   in_range   : address lies inside [BASE_ADDR, BASE_ADDR + SIZE_BYTES)
//   word_index : (address - BASE_ADDR) >> 2, byte lane bits dropped
module sram1_addr_decode #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h2000_0000,
    parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES = 32'h0001_8000,
    parameter int                    IDX_W      = 15
) (
    input  logic [ADDR_WIDTH-1:0] address,
    output logic                  in_range,
    output logic [IDX_W-1:0]      word_index
);

    // One extra bit so a window ending at the top of the address space
    // does not wrap the upper limit back to zero.
    logic [ADDR_WIDTH:0] addr_ext;
    logic [ADDR_WIDTH:0] lo_limit;
    logic [ADDR_WIDTH:0] hi_limit;

    assign addr_ext = {1'b0, address};
    assign lo_limit = {1'b0, BASE_ADDR};
    assign hi_limit = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

    assign in_range = (addr_ext >= lo_limit) && (addr_ext < hi_limit);

    logic [ADDR_WIDTH-1:0] word_offset;

    assign word_offset = (address - BASE_ADDR) >> 2;
    assign word_index  = word_offset[IDX_W-1:0];

    // Upper offset bits are only non-zero outside the window, where
    // in_range already blocks the access.
    logic unused_offset_bits;
    assign unused_offset_bits = ^word_offset[ADDR_WIDTH-1:IDX_W];

endmodule

// File: rtl/sram1.sv
// sram1
// Single-port synchronous 32-bit data SRAM mapped at BASE_ADDR.
// One access per rising clock edge while reset_n is high; no enable.
//   clock   : system clock
//   reset_n : asynchronous active-low reset of the output registers only;
//             the array keeps its contents and is never written in reset
//   bus     : sram1_if slave port (read_write, address, data_in in;
//             data_out, access_error out, both registered)
module sram1
    import sram1_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = SRAM1_BASE,
    parameter logic [ADDR_WIDTH-1:0] SIZE_BYTES = SRAM1_SIZE
) (
    input  logic   clock,
    input  logic   reset_n,
    sram1_if.slave bus
);

    localparam int WORDS = int'(SIZE_BYTES >> 2);
    localparam int IDX_W = sram1_idx_width(32'(SIZE_BYTES));

    generate
        if ((SIZE_BYTES % 4 != 0) || (SIZE_BYTES == 0)) begin : g_bad_size
            $fatal(1, "sram1: SIZE_BYTES must be a non-zero multiple of 4");
        end
    endgenerate

    logic             in_range;
    logic [IDX_W-1:0] word_index;

    sram1_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .SIZE_BYTES (SIZE_BYTES),
        .IDX_W      (IDX_W)
    ) u_decode (
        .address    (bus.address),
        .in_range   (in_range),
        .word_index (word_index)
    );

    logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

    logic do_write;
    assign do_write = bus.read_write && in_range;

    // Array has no reset; gating on reset_n keeps reset from writing.
    always_ff @(posedge clock) begin
        if (reset_n && do_write) begin
            mem[word_index] <= bus.data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_out     <= '0;
            bus.access_error <= 1'b0;
        end else begin
            bus.access_error <= !in_range;
            // Writes leave data_out holding; out-of-range reads return 0.
            if (!bus.read_write) begin
                bus.data_out <= in_range ? mem[word_index] : '0;
            end
        end
    end

endmodule

// File: tb/tb_sram1.sv
// tb_sram1
// Directed, table-driven bench for sram1 with hand-written reset sequence.
module tb_sram1;

    logic clock;
    logic reset_n;

    sram1_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    sram1 dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    localparam int NVEC   = 23;
    localparam int SPLIT  = 13;

    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rw, input logic [31:0] addr, input logic [31:0] din);
        @(negedge clock);
        bus_if.read_write = rw;
        bus_if.address    = addr;
        bus_if.data_in    = din;
    endtask

    task automatic run_vectors(input int first, input int last);
        for (int i = first; i < last; i++) begin
            drive(vecs[i].rw, vecs[i].addr, vecs[i].din);
            @(posedge clock);
            #1;
            check({vecs[i].name, "_dout"}, bus_if.data_out, vecs[i].exp_dout);
            check({vecs[i].name, "_err"}, {31'd0, bus_if.access_error}, {31'd0, vecs[i].exp_err});
        end
    endtask

    task automatic set_vec(input int i, input string name, input logic rw,
                           input logic [31:0] addr, input logic [31:0] din,
                           input logic [31:0] exp_dout, input logic exp_err);
        vecs[i].name     = name;
        vecs[i].rw       = rw;
        vecs[i].addr     = addr;
        vecs[i].din      = din;
        vecs[i].exp_dout = exp_dout;
        vecs[i].exp_err  = exp_err;
    endtask

    initial begin
        // Phase A: window boundaries and error flag behaviour.
        set_vec( 0, "wr_base",      1'b1, 32'h2000_0000, 32'h0123_4567, 32'h0000_0000, 1'b0);
        set_vec( 1, "rd_base",      1'b0, 32'h2000_0000, 32'h1111_1111, 32'h0123_4567, 1'b0);
        set_vec( 2, "wr_past_top",  1'b1, 32'h2001_8000, 32'hFEDC_BA90, 32'h0123_4567, 1'b1);
        set_vec( 3, "rd_past_top",  1'b0, 32'h2001_8000, 32'h0000_0000, 32'h0000_0000, 1'b1);
        set_vec( 4, "wr_top_unal",  1'b1, 32'h2001_7FFF, 32'h89AB_CDEF, 32'h0000_0000, 1'b0);
        set_vec( 5, "rd_top_unal",  1'b0, 32'h2001_7FFF, 32'h0000_0000, 32'h89AB_CDEF, 1'b0);
        set_vec( 6, "rd_top_alig",  1'b0, 32'h2001_7FFC, 32'h0000_0000, 32'h89AB_CDEF, 1'b0);
        set_vec( 7, "wr_below",     1'b1, 32'h1FFF_FFFC, 32'h5555_5555, 32'h89AB_CDEF, 1'b1);
        set_vec( 8, "rd_below",     1'b0, 32'h1FFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1);
        set_vec( 9, "rd_base2",     1'b0, 32'h2000_0000, 32'h0000_0000, 32'h0123_4567, 1'b0);
        // 0x2002_0000 truncates to word 0 if the range gate is missing.
        set_vec(10, "wr_alias",     1'b1, 32'h2002_0000, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
        set_vec(11, "rd_base3",     1'b0, 32'h2000_0000, 32'h0000_0000, 32'h0123_4567, 1'b0);
        set_vec(12, "wr_err_pre",   1'b1, 32'h2001_8000, 32'h0000_0000, 32'h0123_4567, 1'b1);
        // Phase B: back-to-back sweep, data = address ^ 0xA5A5A5A5.
        set_vec(13, "sw_wr0",       1'b1, 32'h2000_0000, 32'h85A5_A5A5, 32'h0123_4567, 1'b0);
        set_vec(14, "sw_wr1",       1'b1, 32'h2000_0004, 32'h85A5_A5A1, 32'h0123_4567, 1'b0);
        set_vec(15, "sw_wr5ffe",    1'b1, 32'h2001_7FF8, 32'h85A4_DA5D, 32'h0123_4567, 1'b0);
        set_vec(16, "sw_wr5fff",    1'b1, 32'h2001_7FFC, 32'h85A4_DA59, 32'h0123_4567, 1'b0);
        set_vec(17, "sw_rd0",       1'b0, 32'h2000_0000, 32'h0000_0000, 32'h85A5_A5A5, 1'b0);
        set_vec(18, "sw_rd1",       1'b0, 32'h2000_0004, 32'h0000_0000, 32'h85A5_A5A1, 1'b0);
        set_vec(19, "sw_rd5ffe",    1'b0, 32'h2001_7FF8, 32'h0000_0000, 32'h85A4_DA5D, 1'b0);
        set_vec(20, "sw_rd5fff",    1'b0, 32'h2001_7FFC, 32'h0000_0000, 32'h85A4_DA59, 1'b0);
        set_vec(21, "raw_wr",       1'b1, 32'h2000_0008, 32'hCAFE_F00D, 32'h85A4_DA59, 1'b0);
        set_vec(22, "raw_rd",       1'b0, 32'h2000_0008, 32'h0000_0000, 32'hCAFE_F00D, 1'b0);

        reset_n             = 1'b0;
        bus_if.read_write   = 1'b0;
        bus_if.address      = 32'h0;
        bus_if.data_in      = 32'h0;

        repeat (2) @(posedge clock);
        #1;
        check("reset_dout", bus_if.data_out, 32'h0);
        check("reset_err", {31'd0, bus_if.access_error}, 32'h0);

        @(negedge clock);
        reset_n = 1'b1;

        run_vectors(0, SPLIT);

        // Reset asserted between edges must clear outputs immediately.
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_dout", bus_if.data_out, 32'h0);
        check("mid_rst_err", {31'd0, bus_if.access_error}, 32'h0);

        // A write presented during reset must not reach the array.
        drive(1'b1, 32'h2000_0000, 32'h7777_7777);
        @(posedge clock);
        #1;
        check("in_rst_dout", bus_if.data_out, 32'h0);
        check("in_rst_err", {31'd0, bus_if.access_error}, 32'h0);

        @(negedge clock);
        reset_n           = 1'b1;
        bus_if.read_write = 1'b0;
        bus_if.address    = 32'h2000_0000;
        bus_if.data_in    = 32'h0;
        @(posedge clock);
        #1;
        check("retain_dout", bus_if.data_out, 32'h0123_4567);
        check("retain_err", {31'd0, bus_if.access_error}, 32'h0);

        run_vectors(SPLIT, NVEC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
